// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sseg_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2
  } state_t;

  // Active-low "everything off" values for the segment bus and anodes.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by the hex value.
  // Listed from F down to 0 so that HEX_SEG[n] is the glyph for n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/sseg_scan_ctrl_hex7seg.sv
// Hex nibble to active-low seven-segment glyph decoder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module hex7seg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the table lives in the package so other display
  // blocks decode identically.
  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with inter-digit blanking guard.
// Latency: outputs registered; new state's values appear on the edge entering it.
// Backpressure: none; free-running scan, inputs sampled once per frame.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int MAXC = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          snap_take;

  // Frame snapshot of the user inputs.
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;
  logic [3:0]    snap_mask;
  logic          snap_lz;

  // Decode path for the digit currently addressed by idx.
  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;
  logic [3:0]    lz_vec;
  logic          cur_blank;

  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // lz_vec[i]: digit i is a leading zero (nibbles i..3 all zero); digit 0 never is.
  assign lz_vec[3] = snap_lz & (snap_digits[15:12] == 4'h0);
  assign lz_vec[2] = lz_vec[3] & (snap_digits[11:8] == 4'h0);
  assign lz_vec[1] = lz_vec[2] & (snap_digits[7:4] == 4'h0);
  assign lz_vec[0] = 1'b0;

  assign cur_nib   = snap_digits[{idx, 2'b00} +: 4];
  assign cur_blank = snap_mask[idx] | lz_vec[idx];

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Next-state, counter, snapshot strobe and next registered outputs.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    snap_take = 1'b0;
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = GUARD;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          snap_take = 1'b1;
        end
      end
      GUARD: begin
        if (cnt == G_LAST) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ON: begin
        if (cnt == D_LAST) begin
          state_nxt = GUARD;
          idx_nxt   = idx + 2'd1;
          cnt_nxt   = '0;
          // Wrapping back to digit 0 starts a new frame.
          snap_take = (idx == 2'd3);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
        cnt_nxt   = '0;
      end
    endcase

    // Disable overrides everything and parks the scan dark.
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
      snap_take = 1'b0;
    end

    // ON is only entered from GUARD (same idx) or held, so the idx-muxed
    // decode always belongs to the digit being lit.
    if (state_nxt == ON) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = cur_blank ? SEG_OFF : cur_seg;
      dp_nxt  = snap_mask[idx] | ~snap_dp[idx];
    end
  end

  // State, digit index and dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture user inputs once at the start of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_mask   <= '0;
      snap_lz     <= 1'b0;
    end else if (snap_take) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_mask   <= blank_mask;
      snap_lz     <= lz_blank;
    end
  end

  // Registered pin drivers; frame_tick marks the first GUARD cycle of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= snap_take;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl against a frame-position reference model.
// Latency: model predicts the outputs visible one step after each clock edge.
// Backpressure: n/a.
module tb_sseg_scan_ctrl;

  localparam int DC    = 8;
  localparam int GC    = 2;
  localparam int SLOT  = DC + GC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model: position within the current frame plus the frame's inputs.
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_mask;
  logic        s_lz;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // Expected pins from frame position: each slot is GC dark cycles then DC lit.
  task automatic model_eval();
    int d, w;
    logic masked, lzb;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    if (m_active) begin
      d = m_pos / SLOT;
      w = m_pos % SLOT;
      e_tick = (m_pos == 0);
      if (w >= GC) begin
        masked = s_mask[d];
        lzb    = s_lz && (d >= 1) && ((s_dig >> (4 * d)) == 16'h0);
        e_an   = ~(4'b0001 << d);
        e_seg  = (masked || lzb) ? 7'h7F : hex_tab[s_dig[4*d +: 4]];
        e_dp   = masked ? 1'b1 : ~s_dp[d];
      end
    end
  endtask

  // Advance one clock edge, update the model with the inputs seen at that edge.
  task automatic cycle();
    @(posedge clk);
    if (rst || !en) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      if (m_pos == 0) begin
        s_dig = digits; s_dp = dp_in; s_mask = blank_mask; s_lz = lz_blank;
      end
    end
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; digits = 16'h0; dp_in = 4'h0; blank_mask = 4'h0; lz_blank = 1'b0;
    #3;
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: an=%b seg=%h dp=%b tick=%b, expected an=1111 seg=7f dp=1 tick=0", an, seg, dp, frame_tick);
    end
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: an=%b seg=%h dp=%b tick=%b, expected an=1111 seg=7f dp=1 tick=0", an, seg, dp, frame_tick);
    end
  endtask

  task automatic test_basic();
    logic [3:0] x_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] x_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    int ticks = 0, hits = 0, d;
    digits = 16'h1234; en = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL basic t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL basic_onehot: an=%b, expected at most one low", an);
      end
      if (frame_tick === 1'b1) ticks++;
      if (m_pos % SLOT == GC) begin
        d = m_pos / SLOT; hits++;
        checks++;
        if (an !== x_an[d] || seg !== x_seg[d]) begin
          errors++;
          $display("FAIL basic_digit%0d: an=%b seg=%h, expected an=%b seg=%h", d, an, seg, x_an[d], x_seg[d]);
        end
      end
    end
    checks++;
    if (ticks != 2 || hits != 8) begin
      errors++; $display("FAIL basic_ticks: ticks=%0d hits=%0d, expected ticks=2 hits=8", ticks, hits);
    end
  endtask

  task automatic test_lz();
    logic [6:0] x_seg [4] = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
    logic       x_dp [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    int f = 0, hits = 0, d;
    for (int c = 0; c < 4 * FRAME && f < 4; c++) begin
      cycle();
      if (e_tick) f++;
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL lz t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL lz_onehot: an=%b, expected at most one low", an);
      end
      if (m_pos % SLOT == GC) begin
        d = m_pos / SLOT;
        if (f == 2) begin
          hits++; checks++;
          if (seg !== x_seg[d] || dp !== x_dp[d]) begin
            errors++;
            $display("FAIL lz_0005_digit%0d: seg=%h dp=%b, expected seg=%h dp=%b", d, seg, dp, x_seg[d], x_dp[d]);
          end
        end else if (f == 3 && d == 0) begin
          hits++; checks++;
          if (seg !== 7'h40) begin
            errors++; $display("FAIL lz_0000_digit0: seg=%h, expected seg=40", seg);
          end
        end
      end
      if (m_pos == FRAME - 1 && f == 1) begin
        digits = 16'h0005; lz_blank = 1'b1; dp_in = 4'b0100;
      end else if (m_pos == FRAME - 1 && f == 2) begin
        digits = 16'h0000;
      end
    end
    checks++;
    if (hits != 5) begin
      errors++; $display("FAIL lz_coverage: hits=%0d, expected 5", hits);
    end
  endtask

  task automatic test_snapshot();
    int f = 0, hits = 0, d;
    for (int c = 0; c < 4 * FRAME && f < 4; c++) begin
      cycle();
      if (e_tick) f++;
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL snap t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL snap_onehot: an=%b, expected at most one low", an);
      end
      if (m_pos % SLOT == GC && m_pos / SLOT >= 2 && (f == 2 || f == 3)) begin
        d = m_pos / SLOT; hits++; checks++;
        if (seg !== ((f == 2) ? 7'h08 : 7'h12)) begin
          errors++;
          $display("FAIL snap_frame%0d_digit%0d: seg=%h, expected seg=%h", f, d, seg, (f == 2) ? 7'h08 : 7'h12);
        end
      end
      if (m_pos == FRAME - 1 && f == 1) begin
        digits = 16'hAAAA; lz_blank = 1'b0; dp_in = 4'h0;
      end else if (f == 2 && m_pos == SLOT + GC + 3) begin
        digits = 16'h5555;
      end
    end
    checks++;
    if (hits != 4) begin
      errors++; $display("FAIL snap_coverage: hits=%0d, expected 4", hits);
    end
  endtask

  task automatic test_mask();
    logic [3:0] x_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] x_seg [4] = '{7'h7F, 7'h0E, 7'h0E, 7'h7F};
    int f = 0, hits = 0, d;
    for (int c = 0; c < 3 * FRAME && f < 3; c++) begin
      cycle();
      if (e_tick) f++;
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL mask t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL mask_onehot: an=%b, expected at most one low", an);
      end
      if (f == 2 && m_pos % SLOT == GC) begin
        d = m_pos / SLOT; hits++; checks++;
        if (an !== x_an[d] || seg !== x_seg[d] || dp !== 1'b1) begin
          errors++;
          $display("FAIL mask_digit%0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=1", d, an, seg, dp, x_an[d], x_seg[d]);
        end
      end
      if (m_pos == FRAME - 1 && f == 1) begin
        digits = 16'hFFFF; blank_mask = 4'b1001;
      end
    end
    blank_mask = 4'h0;
    checks++;
    if (hits != 4) begin
      errors++; $display("FAIL mask_coverage: hits=%0d, expected 4", hits);
    end
  endtask

  task automatic test_en_drop();
    int ph = 0, idle_c = 0;
    digits = 16'h1234;
    for (int c = 0; c < 3 * FRAME; c++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL endrop t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL endrop_onehot: an=%b, expected at most one low", an);
      end
      case (ph)
        0: if (m_active && m_pos == 2 * SLOT + GC + 2) begin en = 1'b0; ph = 1; end
        1: begin
          checks++;
          if (an !== 4'hF || seg !== 7'h7F) begin
            errors++; $display("FAIL endrop_dark: an=%b seg=%h, expected an=1111 seg=7f", an, seg);
          end
          ph = 2;
        end
        2: begin idle_c++; if (idle_c == 3) begin en = 1'b1; ph = 3; end end
        3: begin
          checks++;
          if (frame_tick !== 1'b1 || an !== 4'hF) begin
            errors++; $display("FAIL endrop_restart: tick=%b an=%b, expected tick=1 an=1111", frame_tick, an);
          end
          ph = 4;
        end
        default: ;
      endcase
    end
    checks++;
    if (ph != 4) begin
      errors++; $display("FAIL endrop_timeout: phase=%0d, expected 4", ph);
    end
  endtask

  task automatic test_async_rst();
    int ph = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL arst t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL arst_onehot: an=%b, expected at most one low", an);
      end
      case (ph)
        0: if (m_active && m_pos == SLOT + GC + 3) begin
          #2 rst = 1'b1;
          #1;
          checks++;
          if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++; $display("FAIL arst_immediate: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", an, seg, dp);
          end
          ph = 1;
        end
        1: begin rst = 1'b0; ph = 2; end
        2: begin
          checks++;
          if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL arst_restart: tick=%b, expected tick=1", frame_tick);
          end
          ph = 3;
        end
        default: ;
      endcase
    end
    checks++;
    if (ph != 3) begin
      errors++; $display("FAIL arst_timeout: phase=%0d, expected 3", ph);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 8 * FRAME; c++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL random t=%0t: an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                 $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL random_onehot: an=%b, expected at most one low", an);
      end
      if ($urandom_range(0, 19) == 0) begin
        digits     = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in      = 4'($urandom);
        blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lz_blank   = 1'($urandom);
      end
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_snapshot();
    test_mask();
    test_en_drop();
    test_async_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
